// File: rtl/tlb_op_seq.sv
// -----------------------------------------------------------------------------
// tlb_op_seq
//
// Sequences the CP0 TLB instructions (tlbp, tlbr, tlbwi, tlbwr) in the E
// stage. It holds the pipeline while the TLB search, read or write port is
// used, and returns the result to CP0 as a one-cycle tlb_type_o pulse.
//
// Parameters
//   TLB_LINE_NUM   number of TLB entries (IW = log2(TLB_LINE_NUM))
//
// Optional feature
//   TLB_REFETCH_EN when defined, a REFETCH cycle follows every TLB write.
//                  It raises refetch_o so that fetch is flushed after the
//                  mapping changes. When undefined, refetch_o is tied low.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   op_valid_i           TLB instruction present in E stage
//   tlb_op_i[3:0]        one-hot {tlbwr, tlbwi, tlbr, tlbp}
//   flush_i              exception / pipeline flush (aborts the operation)
//   entry_hi_i           CP0 EntryHi
//   index_i              CP0 Index
//   random_i             CP0 Random
//   data_search_req_i    data-side translation owns the search port
//   s_found_i            search-port hit
//   s_index_i            search-port hit index
//   r_entry_i            read-port data {hi, pagemask, lo1, lo0}
//   stall_o              hold pipeline
//   s_sel_tlbp_o         search port driven by this block
//   s_vpn2_o, s_asid_o   search key
//   r_index_o            read-port index
//   w_en_o, w_index_o    TLB write strobe and index
//   tlb_type_o           one-cycle CP0 update pulse (same encoding as tlb_op_i)
//   index_out_o          tlbp result for CP0 Index
//   entry_out_o          tlbr result for CP0
//   refetch_o            flush fetch after a TLB write
// -----------------------------------------------------------------------------
module tlb_op_seq #(
  parameter int TLB_LINE_NUM = 16,
  localparam int IW = $clog2(TLB_LINE_NUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid_i,
  input  logic [3:0]    tlb_op_i,
  input  logic          flush_i,
  input  logic [31:0]   entry_hi_i,
  input  logic [31:0]   index_i,
  input  logic [31:0]   random_i,
  input  logic          data_search_req_i,
  input  logic          s_found_i,
  input  logic [IW-1:0] s_index_i,
  input  logic [127:0]  r_entry_i,
  output logic          stall_o,
  output logic          s_sel_tlbp_o,
  output logic [18:0]   s_vpn2_o,
  output logic [7:0]    s_asid_o,
  output logic [IW-1:0] r_index_o,
  output logic          w_en_o,
  output logic [IW-1:0] w_index_o,
  output logic [3:0]    tlb_type_o,
  output logic [31:0]   index_out_o,
  output logic [127:0]  entry_out_o,
  output logic          refetch_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PORT,
    S_SEARCH,
    S_READ,
    S_WRITE,
    S_REFETCH,
    S_DONE
  } state_e;

  localparam int OP_TLBP  = 0;
  localparam int OP_TLBR  = 1;
  localparam int OP_TLBWR = 3;

  state_e          state_q, state_d;
  logic [3:0]      op_q;
  logic [18:0]     vpn2_q;
  logic [7:0]      asid_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     index_out_q;
  logic [127:0]    entry_out_q;

  logic            op_onehot;
  logic            accept;

  // EntryHi[12:8] and the upper Index/Random bits carry nothing this block needs.
  logic            unused_bits;
  assign unused_bits = ^{entry_hi_i[12:8], index_i[31:IW], random_i[31:IW]};

  // A power-of-two test. It rejects zero and any pattern with more than one bit set.
  assign op_onehot = (tlb_op_i != 4'b0000) && ((tlb_op_i & (tlb_op_i - 4'd1)) == 4'b0000);
  assign accept    = (state_q == S_IDLE) && op_valid_i && op_onehot && !flush_i;

  // ---------------------------------------------------------------------------
  // Next-state and Moore/Mealy outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    stall_o      = 1'b0;
    s_sel_tlbp_o = 1'b0;
    w_en_o       = 1'b0;
    tlb_type_o   = 4'b0000;
    refetch_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          if (tlb_op_i[OP_TLBP]) begin
            // The data side owns the search port until it releases it.
            state_d = data_search_req_i ? S_WAIT_PORT : S_SEARCH;
          end else if (tlb_op_i[OP_TLBR]) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WAIT_PORT: begin
        stall_o = 1'b1;
        if (flush_i)                 state_d = S_IDLE;
        else if (!data_search_req_i) state_d = S_SEARCH;
      end

      S_SEARCH: begin
        stall_o      = 1'b1;
        s_sel_tlbp_o = 1'b1;
        state_d      = flush_i ? S_IDLE : S_DONE;
      end

      S_READ: begin
        stall_o = 1'b1;
        state_d = flush_i ? S_IDLE : S_DONE;
      end

      S_WRITE: begin
        stall_o = 1'b1;
        w_en_o  = !flush_i;
`ifdef TLB_REFETCH_EN
        state_d = flush_i ? S_IDLE : S_REFETCH;
`else
        state_d = flush_i ? S_IDLE : S_DONE;
`endif
      end

`ifdef TLB_REFETCH_EN
      S_REFETCH: begin
        stall_o   = 1'b1;
        refetch_o = 1'b1;
        state_d   = flush_i ? S_IDLE : S_DONE;
      end
`endif

      S_DONE: begin
        tlb_type_o = flush_i ? 4'b0000 : op_q;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and latched operands
  // ---------------------------------------------------------------------------
  // NOTE: every register here is reset, because the CP0 result outputs must read 0 after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      op_q        <= 4'b0000;
      vpn2_q      <= '0;
      asid_q      <= '0;
      idx_q       <= '0;
      index_out_q <= '0;
      entry_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples its pre-edge value.
      state_q <= state_d;

      if (accept) begin
        op_q   <= tlb_op_i;
        vpn2_q <= entry_hi_i[31:13];
        asid_q <= entry_hi_i[7:0];
        idx_q  <= tlb_op_i[OP_TLBWR] ? random_i[IW-1:0] : index_i[IW-1:0];
      end

      // A flushed search or read must not corrupt the previous CP0 result.
      if (state_q == S_SEARCH && !flush_i) begin
        index_out_q <= {~s_found_i, {(31-IW){1'b0}}, s_index_i};
      end

      if (state_q == S_READ && !flush_i) begin
        entry_out_q <= r_entry_i;
      end
    end
  end

  assign s_vpn2_o    = vpn2_q;
  assign s_asid_o    = asid_q;
  assign r_index_o   = idx_q;
  assign w_index_o   = idx_q;
  assign index_out_o = index_out_q;
  assign entry_out_o = entry_out_q;

endmodule

// File: tb/tb_tlb_op_seq.sv
module tb_tlb_op_seq;

  localparam int TLB_LINE_NUM = 16;
  localparam int IW = 4;

`ifdef TLB_REFETCH_EN
  localparam int WR_STALLS = 3;
  localparam int WR_REFE   = 1;
`else
  localparam int WR_STALLS = 2;
  localparam int WR_REFE   = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          op_valid_i;
  logic [3:0]    tlb_op_i;
  logic          flush_i;
  logic [31:0]   entry_hi_i;
  logic [31:0]   index_i;
  logic [31:0]   random_i;
  logic          data_search_req_i;
  logic          s_found_i;
  logic [IW-1:0] s_index_i;
  logic [127:0]  r_entry_i;
  logic          stall_o;
  logic          s_sel_tlbp_o;
  logic [18:0]   s_vpn2_o;
  logic [7:0]    s_asid_o;
  logic [IW-1:0] r_index_o;
  logic          w_en_o;
  logic [IW-1:0] w_index_o;
  logic [3:0]    tlb_type_o;
  logic [31:0]   index_out_o;
  logic [127:0]  entry_out_o;
  logic          refetch_o;

  tlb_op_seq #(.TLB_LINE_NUM(TLB_LINE_NUM)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .op_valid_i        (op_valid_i),
    .tlb_op_i          (tlb_op_i),
    .flush_i           (flush_i),
    .entry_hi_i        (entry_hi_i),
    .index_i           (index_i),
    .random_i          (random_i),
    .data_search_req_i (data_search_req_i),
    .s_found_i         (s_found_i),
    .s_index_i         (s_index_i),
    .r_entry_i         (r_entry_i),
    .stall_o           (stall_o),
    .s_sel_tlbp_o      (s_sel_tlbp_o),
    .s_vpn2_o          (s_vpn2_o),
    .s_asid_o          (s_asid_o),
    .r_index_o         (r_index_o),
    .w_en_o            (w_en_o),
    .w_index_o         (w_index_o),
    .tlb_type_o        (tlb_type_o),
    .index_out_o       (index_out_o),
    .entry_out_o       (entry_out_o),
    .refetch_o         (refetch_o)
  );

  always #5 clk = ~clk;

  // Per-operation observations gathered while an op runs.
  typedef struct {
    int            stalls;
    int            wen;
    int            refe;
    int            ssel;
    int            pre_wait;
    int            types;
    int            lat;
    logic [3:0]    type_seen;
    logic [IW-1:0] windex;
    logic [IW-1:0] rindex;
    logic [18:0]   vpn;
    logic [7:0]    asid;
    bit            timeout;
  } obs_t;

  // Scoreboard entry: what CP0 should receive for one operation.
  typedef struct {
    logic [3:0]   op;
    logic [31:0]  idx;
    logic [127:0] entry;
    int           stalls;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [127:0] PATTERN_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] PATTERN_B = 128'hdead_beef_0000_1111_2222_3333_cafe_f00d;

  task automatic drive_idle();
    op_valid_i        = 1'b0;
    tlb_op_i          = 4'b0000;
    flush_i           = 1'b0;
    data_search_req_i = 1'b0;
  endtask

  // Issues one op and observes it until the first non-stall cycle after accept,
  // then one further cycle to confirm that the pulse is only one cycle long.
  // dsr_cycles: number of cycles (starting at accept) that data_search_req_i is held high.
  task automatic run_op(input logic [3:0] op, input int dsr_cycles, output obs_t o);
    bit done = 1'b0;
    bit seen_ssel = 1'b0;
    o.stalls = 0; o.wen = 0; o.refe = 0; o.ssel = 0; o.pre_wait = 0;
    o.types = 0; o.lat = -1; o.type_seen = 4'b0000; o.windex = '0;
    o.rindex = '0; o.vpn = '0; o.asid = '0; o.timeout = 1'b0;
    @(negedge clk);
    op_valid_i        = 1'b1;
    tlb_op_i          = op;
    data_search_req_i = (dsr_cycles > 0);
    #1;
    if (stall_o) o.stalls++;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      op_valid_i        = 1'b0;
      tlb_op_i          = 4'b0000;
      data_search_req_i = (k < dsr_cycles);
      #1;
      if (k == 1) o.rindex = r_index_o;
      if (stall_o) o.stalls++;
      if (stall_o && !s_sel_tlbp_o && !seen_ssel && op == 4'b0001) o.pre_wait++;
      if (w_en_o) begin o.wen++; o.windex = w_index_o; end
      if (refetch_o) o.refe++;
      if (s_sel_tlbp_o) begin
        o.ssel++; seen_ssel = 1'b1; o.vpn = s_vpn2_o; o.asid = s_asid_o;
      end
      if (tlb_type_o != 4'b0000) begin o.types++; o.type_seen = tlb_type_o; o.lat = k; end
      if (!stall_o) begin done = 1'b1; break; end
    end
    if (!done) o.timeout = 1'b1;
    @(negedge clk);
    drive_idle();
    #1;
    if (tlb_type_o != 4'b0000) o.types++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive_idle();
    entry_hi_i = '0; index_i = '0; random_i = '0;
    s_found_i = 1'b0; s_index_i = '0; r_entry_i = '0;
    @(negedge clk); #1;
    n_cmp++;
    if ({stall_o, s_sel_tlbp_o, w_en_o, tlb_type_o, refetch_o} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got stall=%b ssel=%b wen=%b type=%b refetch=%b, expected all 0",
               stall_o, s_sel_tlbp_o, w_en_o, tlb_type_o, refetch_o);
    end
    n_cmp++;
    if (index_out_o !== 32'h0 || entry_out_o !== 128'h0) begin
      n_err++;
      $display("FAIL reset_results: got index_out=%h entry_out=%h, expected 0", index_out_o, entry_out_o);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_tlbp_hit();
    obs_t o; exp_t e;
    entry_hi_i = 32'h0040_2005; s_found_i = 1'b1; s_index_i = 4'd5;
    sb.push_back('{op: 4'b0001, idx: 32'h0000_0005, entry: 128'h0, stalls: 2});
    run_op(4'b0001, 0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.timeout || o.type_seen !== e.op || o.types != 1 || o.lat != 2) begin
      n_err++;
      $display("FAIL tlbp_type: got type=%b pulses=%0d lat=%0d timeout=%0d, expected %b x1 at 2",
               o.type_seen, o.types, o.lat, o.timeout, e.op);
    end
    n_cmp++;
    if (o.stalls != e.stalls) begin
      n_err++; $display("FAIL tlbp_stalls: got %0d expected %0d", o.stalls, e.stalls);
    end
    n_cmp++;
    if (o.ssel != 1 || o.vpn !== 19'h00201 || o.asid !== 8'h05) begin
      n_err++;
      $display("FAIL tlbp_key: got ssel=%0d vpn2=%h asid=%h, expected 1 00201 05", o.ssel, o.vpn, o.asid);
    end
    n_cmp++;
    if (index_out_o !== e.idx || o.wen != 0) begin
      n_err++; $display("FAIL tlbp_index: got %h wen=%0d expected %h wen=0", index_out_o, o.wen, e.idx);
    end
  endtask

  task automatic test_tlbp_wait_miss();
    obs_t o; exp_t e;
    entry_hi_i = 32'hFFFF_E0AB; s_found_i = 1'b0; s_index_i = 4'd0;
    sb.push_back('{op: 4'b0001, idx: 32'h8000_0000, entry: 128'h0, stalls: 5});
    run_op(4'b0001, 3, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.pre_wait != 3 || o.ssel != 1) begin
      n_err++;
      $display("FAIL tlbp_wait: got wait_cycles=%0d ssel_cycles=%0d, expected 3 and 1", o.pre_wait, o.ssel);
    end
    n_cmp++;
    if (o.stalls != e.stalls || o.lat != 5 || o.type_seen !== e.op || o.types != 1) begin
      n_err++;
      $display("FAIL tlbp_wait_timing: got stalls=%0d lat=%0d type=%b pulses=%0d, expected %0d 5 %b 1",
               o.stalls, o.lat, o.type_seen, o.types, e.stalls, e.op);
    end
    n_cmp++;
    if (index_out_o !== e.idx || o.vpn !== 19'h7FFFF || o.asid !== 8'hAB) begin
      n_err++;
      $display("FAIL tlbp_miss: got index=%h vpn2=%h asid=%h, expected %h 7ffff ab",
               index_out_o, o.vpn, o.asid, e.idx);
    end
  endtask

  task automatic test_tlbr();
    obs_t o; exp_t e;
    index_i = 32'hFFFF_FFF3; r_entry_i = PATTERN_A;
    sb.push_back('{op: 4'b0010, idx: 32'h8000_0000, entry: PATTERN_A, stalls: 2});
    run_op(4'b0010, 0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.rindex !== 4'd3) begin
      n_err++; $display("FAIL tlbr_index: got %0d expected 3", o.rindex);
    end
    n_cmp++;
    if (entry_out_o !== e.entry) begin
      n_err++; $display("FAIL tlbr_entry: got %h expected %h", entry_out_o, e.entry);
    end
    n_cmp++;
    if (o.type_seen !== e.op || o.types != 1 || o.stalls != e.stalls || o.lat != 2 || o.ssel != 0) begin
      n_err++;
      $display("FAIL tlbr_type: got type=%b pulses=%0d stalls=%0d lat=%0d ssel=%0d, expected %b 1 %0d 2 0",
               o.type_seen, o.types, o.stalls, o.lat, o.ssel, e.op, e.stalls);
    end
    n_cmp++;
    if (index_out_o !== e.idx) begin
      n_err++; $display("FAIL tlbr_keeps_index: got %h expected %h", index_out_o, e.idx);
    end
  endtask

  task automatic test_write(input logic [3:0] op, input logic [31:0] idx, input logic [31:0] rnd,
                            input logic [IW-1:0] exp_windex);
    obs_t o; exp_t e;
    index_i = idx; random_i = rnd;
    sb.push_back('{op: op, idx: 32'h8000_0000, entry: PATTERN_A, stalls: WR_STALLS});
    run_op(op, 0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.wen != 1 || o.windex !== exp_windex) begin
      n_err++;
      $display("FAIL write_%b_port: got wen_cycles=%0d w_index=%0d, expected 1 and %0d",
               op, o.wen, o.windex, exp_windex);
    end
    n_cmp++;
    if (o.refe != WR_REFE || o.stalls != e.stalls) begin
      n_err++;
      $display("FAIL write_%b_refetch: got refetch_cycles=%0d stalls=%0d, expected %0d and %0d",
               op, o.refe, o.stalls, WR_REFE, e.stalls);
    end
    n_cmp++;
    if (o.type_seen !== e.op || o.types != 1 || o.lat != e.stalls) begin
      n_err++;
      $display("FAIL write_%b_type: got type=%b pulses=%0d lat=%0d, expected %b 1 %0d",
               op, o.type_seen, o.types, o.lat, e.op, e.stalls);
    end
    n_cmp++;
    if (index_out_o !== e.idx || entry_out_o !== e.entry) begin
      n_err++;
      $display("FAIL write_%b_results_kept: got index=%h entry=%h", op, index_out_o, entry_out_o);
    end
  endtask

  task automatic test_illegal_op();
    @(negedge clk);
    op_valid_i = 1'b1; tlb_op_i = 4'b0011;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL illegal_accept: got stall=%b expected 0", stall_o);
    end
    @(negedge clk);
    tlb_op_i = 4'b0001; flush_i = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || tlb_type_o !== 4'b0000 || s_sel_tlbp_o !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_idle: got stall=%b type=%b ssel=%b expected 0", stall_o, tlb_type_o, s_sel_tlbp_o);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || tlb_type_o !== 4'b0000 || w_en_o !== 1'b0 || s_sel_tlbp_o !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_after: got stall=%b type=%b wen=%b ssel=%b expected 0",
               stall_o, tlb_type_o, w_en_o, s_sel_tlbp_o);
    end
  endtask

  task automatic test_flush_write();
    index_i = 32'd6;
    @(negedge clk);
    op_valid_i = 1'b1; tlb_op_i = 4'b0100;
    #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_err++; $display("FAIL flush_accept: got stall=%b expected 1", stall_o);
    end
    @(negedge clk);
    op_valid_i = 1'b0; tlb_op_i = 4'b0000; flush_i = 1'b1;
    #1;
    n_cmp++;
    if (w_en_o !== 1'b0 || tlb_type_o !== 4'b0000) begin
      n_err++; $display("FAIL flush_write: got wen=%b type=%b expected 0 0", w_en_o, tlb_type_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || tlb_type_o !== 4'b0000 || refetch_o !== 1'b0 || w_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: got stall=%b type=%b refetch=%b wen=%b expected all 0",
               stall_o, tlb_type_o, refetch_o, w_en_o);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (tlb_type_o !== 4'b0000) begin
      n_err++; $display("FAIL flush_no_pulse: got type=%b expected 0000", tlb_type_o);
    end
  endtask

  task automatic test_reset_mid_search();
    exp_t e;
    entry_hi_i = 32'h0040_2005; s_found_i = 1'b1; s_index_i = 4'd5;
    @(negedge clk);
    op_valid_i = 1'b1; tlb_op_i = 4'b0001;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++;
    if (s_sel_tlbp_o !== 1'b1) begin
      n_err++; $display("FAIL rst_search_entered: got ssel=%b expected 1", s_sel_tlbp_o);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (s_sel_tlbp_o !== 1'b0 || stall_o !== 1'b0 || index_out_o !== 32'h0 || entry_out_o !== 128'h0) begin
      n_err++;
      $display("FAIL rst_mid_search: got ssel=%b stall=%b index=%h entry=%h expected all 0",
               s_sel_tlbp_o, stall_o, index_out_o, entry_out_o);
    end
    // Release reset and issue a tlbr so it is accepted on the very next rising edge.
    @(negedge clk);
    resetn = 1'b1;
    index_i = 32'd11; r_entry_i = PATTERN_B;
    op_valid_i = 1'b1; tlb_op_i = 4'b0010;
    sb.push_back('{op: 4'b0010, idx: 32'h0, entry: PATTERN_B, stalls: 2});
    #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_err++; $display("FAIL rst_first_accept: got stall=%b expected 1", stall_o);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++;
    if (stall_o !== 1'b1 || r_index_o !== 4'd11) begin
      n_err++; $display("FAIL rst_first_read: got stall=%b r_index=%0d expected 1 11", stall_o, r_index_o);
    end
    @(negedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (tlb_type_o !== e.op || entry_out_o !== e.entry || index_out_o !== e.idx || stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_first_done: got type=%b entry=%h index=%h stall=%b expected %b %h %h 0",
               tlb_type_o, entry_out_o, index_out_o, stall_o, e.op, e.entry, e.idx);
    end
  endtask

  initial begin
    test_reset();
    test_tlbp_hit();
    test_tlbp_wait_miss();
    test_tlbr();
    test_write(4'b0100, 32'd7, 32'd9, 4'd7);
    test_write(4'b1000, 32'd2, 32'd9, 4'd9);
    test_illegal_op();
    test_flush_write();
    test_reset_mid_search();
    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tlb_op_seq.md
TLB_OP_SEQ -- requirements
Module: tlb_op_seq

Interface
REQ-001 SHALL have parameter TLB_LINE_NUM, default 16, number of TLB entries; IW = log2(TLB_LINE_NUM).
REQ-002 SHALL run on one clock with asynchronous active-low reset, ports as follows:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- op_valid_i  in  1  TLB instruction present in E stage
- tlb_op_i  in  4  one-hot {tlbwr,tlbwi,tlbr,tlbp}
- flush_i  in  1  exception/pipeline flush
- entry_hi_i  in  32  CP0 EntryHi
- index_i  in  32  CP0 Index
- random_i  in  32  CP0 Random
- data_search_req_i  in  1  data-side translation needs the search port
- s_found_i  in  1  search-port hit
- s_index_i  in  IW  search-port hit index
- r_entry_i  in  128  read-port data {hi,pagemask,lo1,lo0}
- stall_o  out  1  hold pipeline
- s_sel_tlbp_o  out  1  search port driven by this block
- s_vpn2_o  out  19  search VPN2
- s_asid_o  out  8  search ASID
- r_index_o  out  IW  read-port index
- w_en_o  out  1  TLB write strobe
- w_index_o  out  IW  write index
- tlb_type_o  out  4  one-cycle CP0 update pulse, same encoding as tlb_op_i
- index_out_o  out  32  tlbp result to CP0 Index
- entry_out_o  out  128  tlbr result to CP0
- refetch_o  out  1  flush fetch after TLB write

Function
REQ-003 SHALL implement FSM IDLE, WAIT_PORT, SEARCH, READ, WRITE, REFETCH, DONE.
REQ-004 SHALL, in IDLE, accept op when op_valid_i & exactly one tlb_op_i bit & ~flush_i; latch op, entry_hi_i, and write index (index_i[IW-1:0] for tlbwi, random_i[IW-1:0] for tlbwr); otherwise stay IDLE, stall_o=0.
REQ-005 SHALL assert stall_o combinationally in the accept cycle and in every state except IDLE and DONE.
REQ-006 tlbp: SHALL go to WAIT_PORT if data_search_req_i, else SEARCH; WAIT_PORT holds until data_search_req_i=0 (data side has priority).
REQ-007 SEARCH: s_sel_tlbp_o=1, s_vpn2_o/s_asid_o=latched EntryHi[31:13]/[7:0]; SHALL register index_out_o = {~s_found_i, 31-IW zeros, s_index_i}; next DONE.
REQ-008 tlbr: READ drives r_index_o=latched index_i[IW-1:0]; SHALL register r_entry_i into entry_out_o at end of READ; next DONE.
REQ-009 tlbwi/tlbwr: WRITE asserts w_en_o=~flush_i for one cycle with w_index_o=latched index; next REFETCH (macro on) or DONE.
REQ-010 DONE: tlb_type_o=latched op for exactly one cycle, stall_o=0; next IDLE.
REQ-011 flush_i in any non-IDLE state SHALL return to IDLE next cycle with no tlb_type_o pulse and, in WRITE, no w_en_o.
REQ-012 s_sel_tlbp_o, w_en_o, tlb_type_o, refetch_o SHALL be 0 outside their stated states.
REQ-013 Latency without contention: tlbp/tlbr/tlbwi 2 stall cycles; tlb_type_o pulse 2 cycles after accept.

Reset
REQ-014 resetn=0 SHALL immediately force IDLE and zero all registered outputs (index_out_o, entry_out_o, latched op/index) regardless of state.
REQ-015 After resetn deasserts, the first op SHALL be acceptable on the first rising edge.

Configuration
REQ-016 With TLB_REFETCH_EN defined: REFETCH state follows WRITE for one cycle, refetch_o=1, stall_o=1 (tlbwi/tlbwr stall 3 cycles); without it refetch_o tied 0, WRITE goes straight to DONE.

Verification
REQ-017 tlbp, EntryHi=0x00402005, s_found_i=1, s_index_i=5 -> s_vpn2_o=0x00201, s_asid_o=0x05, index_out_o=0x00000005, tlb_type_o=4'b0001 one cycle, 2 stall cycles.
REQ-018 tlbp miss with data_search_req_i high 3 cycles -> WAIT_PORT 3 cycles, s_sel_tlbp_o=0 throughout, then index_out_o=0x80000000.
REQ-019 tlbwr, random_i=9 -> w_en_o one cycle, w_index_o=9; refetch_o=1 one cycle iff TLB_REFETCH_EN; tlb_type_o=4'b1000.
REQ-020 tlbr index_i=3, r_entry_i=pattern -> r_index_o=3, entry_out_o=pattern, tlb_type_o=4'b0010.
REQ-021 tlbwi with flush_i in WRITE -> w_en_o=0, no tlb_type_o pulse, IDLE next cycle; resetn pulled low mid-SEARCH -> outputs 0 immediately.
REQ-022 op_valid_i with tlb_op_i=4'b0011 -> ignored, stall_o=0.
